// File: rtl/burst_read_responder.sv
// Burst read responder: queues read bursts, fetches 64-byte beats from a
// 1-cycle-latency memory port and streams them back in request order.
module burst_read_responder #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 64,
   parameter int REQ_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_req,
   output logic                  rd_req_ack,
   input  logic [7:0]            rd_len,
   input  logic [ADDR_WIDTH-1:0] rd_address,
   output logic                  rd_axi_valid,
   input  logic                  rd_axi_ready,
   output logic                  rd_axi_last,
   output logic [DATA_WIDTH-1:0] rd_axi_data,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-7:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  busy,
   output logic [1:0]            err_status
);
   localparam int BA_W  = ADDR_WIDTH - 6;
   localparam int QP_W  = $clog2(REQ_DEPTH);
   localparam int CNT_W = QP_W + 1;

   typedef enum logic {IDLE, STREAM} state_t;

   // request queue
   logic [BA_W-1:0]  q_addr [REQ_DEPTH];
   logic [7:0]       q_len  [REQ_DEPTH];
   logic [QP_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0] q_count;
   logic             q_full, push, q_pop;

   // engine
   state_t          state, state_nx;
   logic [BA_W-1:0] beat_addr, beat_addr_nx, src_addr;
   logic [7:0]      remaining, remaining_nx, src_rem;
   logic            have, issue, credit_ok;
   logic            inflight, inflight_last;

   // 2-entry output buffer
   logic [DATA_WIDTH-1:0] buf_data [2];
   logic [1:0]            buf_last;
   logic                  buf_head;
   logic [1:0]            buf_count;
   logic                  from_buf, out_pop, buf_wr, buf_pop, buf_wr_idx;
   logic [2:0]            occ;

   logic [7:0] span;
   logic       crosses;

   assign q_full     = (q_count == CNT_W'(REQ_DEPTH));
   assign rd_req_ack = rd_req & ~q_full & rst_n;
   assign push       = rd_req & rd_req_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + QP_W'(1);
         if (q_pop) rd_ptr <= rd_ptr + QP_W'(1);
         q_count <= q_count + CNT_W'(push) - CNT_W'(q_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= rd_address[ADDR_WIDTH-1:6];
         q_len[wr_ptr]  <= rd_len;
      end
   end

   // Slots already committed: buffered beats plus the one returning from memory,
   // less whatever the requester takes this cycle.
   assign occ       = 3'(buf_count) + 3'(inflight) - 3'(out_pop);
   assign credit_ok = (occ < 3'd2);

   // In IDLE the head is popped and its first beat may issue in the same cycle.
   always_comb begin
      state_nx     = state;
      beat_addr_nx = beat_addr;
      remaining_nx = remaining;
      q_pop        = 1'b0;
      src_addr     = beat_addr;
      src_rem      = remaining;
      have         = (state == STREAM);
      if (state == IDLE && q_count != '0) begin
         q_pop        = 1'b1;
         src_addr     = q_addr[rd_ptr];
         src_rem      = q_len[rd_ptr];
         have         = 1'b1;
         state_nx     = STREAM;
         beat_addr_nx = q_addr[rd_ptr];
         remaining_nx = q_len[rd_ptr];
      end
      issue = have & credit_ok;
      if (issue) begin
         if (src_rem == 8'd0) begin
            if (state == STREAM && q_count != '0) begin
               q_pop        = 1'b1;
               beat_addr_nx = q_addr[rd_ptr];
               remaining_nx = q_len[rd_ptr];
            end else begin
               state_nx = IDLE;
            end
         end else begin
            beat_addr_nx = src_addr + BA_W'(1);
            remaining_nx = src_rem - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         beat_addr     <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= state_nx;
         beat_addr     <= beat_addr_nx;
         remaining     <= remaining_nx;
         inflight      <= issue;
         inflight_last <= issue & (src_rem == 8'd0);
      end
   end

   assign mem_rd_en   = issue;
   assign mem_rd_addr = issue ? src_addr : '0;

   // A returning beat is presented directly when the buffer is empty and only
   // lands in the buffer if the requester does not take it straight away.
   assign from_buf     = (buf_count != 2'd0);
   assign rd_axi_valid = from_buf | inflight;
   assign out_pop      = rd_axi_valid & rd_axi_ready;
   assign buf_pop      = out_pop & from_buf;
   assign buf_wr       = inflight & (from_buf | ~rd_axi_ready);
   assign buf_wr_idx   = buf_head ^ (buf_count == 2'd1);

   always_comb begin
      rd_axi_data = '0;
      rd_axi_last = 1'b0;
      if (from_buf) begin
         rd_axi_data = buf_data[buf_head];
         rd_axi_last = buf_last[buf_head];
      end else if (inflight) begin
         rd_axi_data = mem_rd_data;
         rd_axi_last = inflight_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_count <= 2'd0;
         buf_head  <= 1'b0;
      end else begin
         buf_count <= buf_count + 2'(buf_wr) - 2'(buf_pop);
         if (buf_pop) buf_head <= ~buf_head;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_wr) begin
         buf_data[buf_wr_idx] <= mem_rd_data;
         buf_last[buf_wr_idx] <= inflight_last;
      end
   end

   assign span    = {2'b00, rd_address[11:6]} + {1'b0, rd_len[6:0]};
   assign crosses = (span > 8'd63) | (rd_len > 8'd63);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_status <= 2'b00;
      end else if (push) begin
         if (rd_address[5:0] != 6'd0) err_status[0] <= 1'b1;
         if (crosses)                 err_status[1] <= 1'b1;
      end
   end

   assign busy = (q_count != '0) | (state != IDLE) | inflight | (buf_count != 2'd0);

endmodule
